// File: rtl/calc_seq_arbiter.sv
// Round-robin two-requester front end for the 8-bit queue calculator: one command in flight.
// Optional macro CALC_SEQ_AUTOCLR_EN adds calc_clr and a CLEAR state that wipes a sticky calculator error.
module calc_seq_arbiter #(
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_in,
    input  logic [2:0]        req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_in,
    input  logic [2:0]        req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_empty,
    output logic              rsp_err,
    output logic [DATA_W-1:0] calc_in,
    output logic [2:0]        calc_op,
    output logic              calc_apply,
    input  logic [DATA_W-1:0] calc_tail,
    input  logic              calc_empty,
    input  logic              calc_err,
`ifdef CALC_SEQ_AUTOCLR_EN
    output logic              calc_clr,
`endif
    output logic              busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
`ifdef CALC_SEQ_AUTOCLR_EN
        S_CLEAR,
`endif
        S_RESP
    } state_t;

    localparam logic [3:0] LP_WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_last_grant;
    logic [3:0]          r_cnt;
    logic [DATA_W-1:0]   r_calc_in;
    logic [2:0]          r_calc_op;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_empty;
    logic                r_rsp_err;

    logic                w_any_req;
    logic                w_grant1;
    logic                w_rsp_ready;
    logic                w_clr;

    // On a tie the requester that did not win last time takes the grant.
    assign w_any_req   = req0_valid | req1_valid;
    assign w_grant1    = req1_valid & (~req0_valid | ~r_last_grant);
    assign w_rsp_ready = r_last_grant ? rsp1_ready : rsp0_ready;

    assign calc_in   = r_calc_in;
    assign calc_op   = r_calc_op;
    assign rsp_data  = r_rsp_data;
    assign rsp_empty = r_rsp_empty;
    assign rsp_err   = r_rsp_err;
    assign busy      = (r_state != S_IDLE);

`ifdef CALC_SEQ_AUTOCLR_EN
    assign calc_clr = w_clr;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        w_state_next = r_state;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;
        calc_apply   = 1'b0;
        w_clr        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    req0_ready   = ~w_grant1;
                    req1_ready   = w_grant1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                calc_apply   = 1'b1;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp0_valid = ~r_last_grant;
                rsp1_valid = r_last_grant;
                if (w_rsp_ready) begin
`ifdef CALC_SEQ_AUTOCLR_EN
                    w_state_next = r_rsp_err ? S_CLEAR : S_IDLE;
`else
                    w_state_next = S_IDLE;
`endif
                end
            end
`ifdef CALC_SEQ_AUTOCLR_EN
            S_CLEAR: begin
                w_clr        = 1'b1;
                w_state_next = S_IDLE;
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_cnt        <= 4'd0;
            r_calc_in    <= '0;
            r_calc_op    <= 3'd0;
            r_rsp_data   <= '0;
            r_rsp_empty  <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_calc_in    <= w_grant1 ? req1_in : req0_in;
                        r_calc_op    <= w_grant1 ? req1_op : req0_op;
                        r_last_grant <= w_grant1;
                    end
                end
                S_ISSUE: r_cnt <= LP_WAIT_LOAD;
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_data  <= calc_tail;
                        r_rsp_empty <= calc_empty;
                        r_rsp_err   <= calc_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_seq_arbiter.sv
// Directed self-checking bench for calc_seq_arbiter with a small behavioural queue calculator.
// Adapts to CALC_SEQ_AUTOCLR_EN when that macro is defined.
module tb_calc_seq_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_in = 8'h00, req1_in = 8'h00;
    logic [2:0] req0_op = 3'd0, req1_op = 3'd0;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready = 1'b0, rsp1_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_empty, rsp_err;
    logic [7:0] calc_in;
    logic [2:0] calc_op;
    logic       calc_apply;
    logic [7:0] calc_tail;
    logic       calc_empty, calc_err;
    logic       busy;
    logic       m_clr;

    always #5 clk = ~clk;

    calc_seq_arbiter #(.WAIT_CYCLES(2), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_in(req0_in), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_in(req1_in), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .rsp_empty(rsp_empty), .rsp_err(rsp_err),
        .calc_in(calc_in), .calc_op(calc_op), .calc_apply(calc_apply),
        .calc_tail(calc_tail), .calc_empty(calc_empty), .calc_err(calc_err),
`ifdef CALC_SEQ_AUTOCLR_EN
        .calc_clr(m_clr),
`endif
        .busy(busy)
    );

`ifndef CALC_SEQ_AUTOCLR_EN
    assign m_clr = 1'b0;
`endif

    // Calculator stand-in: op 0 pushes, op 4 divides tail by the entry below (zero divisor -> sticky error).
    logic [7:0] m_mem [16];
    logic [3:0] m_cnt;
    logic       m_err;

    assign calc_tail  = (m_cnt == 4'd0) ? 8'h00 : m_mem[m_cnt - 4'd1];
    assign calc_empty = (m_cnt == 4'd0);
    assign calc_err   = m_err;

    always @(posedge clk) begin
        if (rst || m_clr) begin
            m_cnt <= 4'd0;
            m_err <= 1'b0;
        end else if (calc_apply && !m_err) begin
            case (calc_op)
                3'd0: if (m_cnt != 4'd15) begin
                    m_mem[m_cnt] <= calc_in;
                    m_cnt        <= m_cnt + 4'd1;
                end
                3'd4: if (m_cnt < 4'd2 || m_mem[m_cnt - 4'd2] == 8'h00) begin
                    m_err <= 1'b1;
                end else begin
                    m_mem[m_cnt - 4'd2] <= m_mem[m_cnt - 4'd1] / m_mem[m_cnt - 4'd2];
                    m_cnt               <= m_cnt - 4'd1;
                end
                default: ;
            endcase
        end
    end

    int cyc_n = 0, apply_cnt = 0, last_apply = -100, apply_gap = 0;
    bit both_rsp = 1'b0, rsp1_seen = 1'b0;

    always @(posedge clk) begin
        cyc_n <= cyc_n + 1;
        if (calc_apply) begin
            apply_cnt  <= apply_cnt + 1;
            apply_gap  <= cyc_n - last_apply;
            last_apply <= cyc_n;
        end
        if (rsp0_valid && rsp1_valid) both_rsp <= 1'b1;
        if (rsp1_valid) rsp1_seen <= 1'b1;
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic run0(input logic [7:0] din, input logic [2:0] op,
                        output logic [7:0] d, output logic e, output logic er);
        int i;
        req0_in = din; req0_op = op; req0_valid = 1'b1;
        #1;
        i = 0;
        while (!req0_ready && i < 12) begin cyc(); #1; i++; end
        check("run0_grant", 32'(req0_ready), 32'd1);
        cyc();
        req0_valid = 1'b0;
        #1;
        i = 0;
        while (!rsp0_valid && i < 12) begin cyc(); #1; i++; end
        check("run0_rsp", 32'(rsp0_valid), 32'd1);
        d = rsp_data; e = rsp_empty; er = rsp_err;
        rsp0_ready = 1'b1;
        cyc();
        rsp0_ready = 1'b0;
        #1;
    endtask

    initial begin
        int a0;
        int got;
        logic [7:0] d;
        logic       e, er;

        // Reset state
        rst = 1'b1;
        repeat (3) cyc();
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_apply", 32'(calc_apply), 32'd0);
        check("rst_calc_in", 32'(calc_in), 32'd0);
        check("rst_calc_op", 32'(calc_op), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_flags", 32'({rsp_empty, rsp_err, rsp0_valid, rsp1_valid}), 32'd0);
        check("rst_readies", 32'({req0_ready, req1_ready}), 32'd0);
        rst = 1'b0;

        // Single request from req0: push 0x05
        cyc();
        req0_valid = 1'b1; req0_in = 8'h05; req0_op = 3'd0;
        #1;
        check("t1_ready0", 32'(req0_ready), 32'd1);
        check("t1_ready1", 32'(req1_ready), 32'd0);
        cyc();
        req0_valid = 1'b0;
        #1;
        check("t1_apply", 32'(calc_apply), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_calc_in", 32'(calc_in), 32'h05);
        check("t1_ready_drop", 32'(req0_ready), 32'd0);
        cyc(); #1;
        check("t1_apply_one", 32'(calc_apply), 32'd0);
        cyc(); #1;
        check("t1_no_rsp_early", 32'(rsp0_valid), 32'd0);
        cyc(); #1;
        check("t1_rsp0", 32'(rsp0_valid), 32'd1);
        check("t1_rsp1", 32'(rsp1_valid), 32'd0);
        check("t1_data", 32'(rsp_data), 32'h05);
        check("t1_flags", 32'({rsp_empty, rsp_err}), 32'd0);
        rsp0_ready = 1'b1;
        cyc();
        rsp0_ready = 1'b0;
        #1;
        check("t1_rsp_drop", 32'(rsp0_valid), 32'd0);
        check("t1_idle", 32'(busy), 32'd0);
        check("t1_hold_in", 32'(calc_in), 32'h05);
        check("t1_apply_cnt", 32'(apply_cnt), 32'd1);
        check("t1_rsp1_never", 32'(rsp1_seen), 32'd0);

        // Backpressure on rsp1 while req0 waits
        req1_valid = 1'b1; req1_in = 8'h2A; req1_op = 3'd0;
        #1;
        check("bp_ready1", 32'(req1_ready), 32'd1);
        cyc();
        req1_valid = 1'b0;
        #1;
        check("bp_apply", 32'(calc_apply), 32'd1);
        repeat (3) cyc();
        #1;
        check("bp_rsp1", 32'(rsp1_valid), 32'd1);
        check("bp_data", 32'(rsp_data), 32'h2A);
        req0_valid = 1'b1; req0_in = 8'h77; req0_op = 3'd0;
        a0 = apply_cnt;
        for (int i = 0; i < 10; i++) begin
            cyc(); #1;
            check("bp_hold_valid", 32'(rsp1_valid), 32'd1);
            check("bp_hold_data", 32'(rsp_data), 32'h2A);
            check("bp_no_ready0", 32'(req0_ready), 32'd0);
            check("bp_no_apply", 32'(calc_apply), 32'd0);
        end
        check("bp_apply_cnt", 32'(apply_cnt - a0), 32'd0);
        rsp1_ready = 1'b1;
        cyc();
        rsp1_ready = 1'b0;
        #1;
        check("bp_rsp1_drop", 32'(rsp1_valid), 32'd0);
        check("bp_grant0", 32'(req0_ready), 32'd1);
        cyc();
        req0_valid = 1'b0;
        #1;
        check("bp_calc_in", 32'(calc_in), 32'h77);
        repeat (3) cyc();
        #1;
        check("bp_rsp0_data", 32'({rsp0_valid, rsp_data}), 32'h177);
        rsp0_ready = 1'b1;
        cyc();
        rsp0_ready = 1'b0;
        #1;

        // Reset while in WAIT
        req1_valid = 1'b1; req1_in = 8'h33; req1_op = 3'd0;
        #1;
        check("rw_ready1", 32'(req1_ready), 32'd1);
        cyc();
        req1_valid = 1'b0;
        cyc();
        rst = 1'b1;
        #1;
        check("rw_busy_before", 32'(busy), 32'd1);
        cyc(); #1;
        check("rw_busy", 32'(busy), 32'd0);
        check("rw_apply", 32'(calc_apply), 32'd0);
        check("rw_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        check("rw_clear", 32'({calc_in, rsp_data}), 32'd0);
        rst = 1'b0;
        repeat (4) cyc();
        #1;
        check("rw_no_rsp", 32'({rsp0_valid, rsp1_valid, busy}), 32'd0);

        // Contention from reset: grants alternate 0,1,0,1
        req0_valid = 1'b1; req0_in = 8'h11; req0_op = 3'd0;
        req1_valid = 1'b1; req1_in = 8'h22; req1_op = 3'd0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            got = -1;
            for (int i = 0; i < 12; i++) begin
                if (req0_ready) begin got = 0; break; end
                if (req1_ready) begin got = 1; break; end
                cyc(); #1;
            end
            check("ct_grant", 32'(got), 32'(k % 2));
            for (int i = 0; i < 12; i++) begin
                cyc(); #1;
                if (rsp0_valid || rsp1_valid) break;
            end
            check("ct_rsp_sel", 32'({rsp0_valid, rsp1_valid}), (k % 2 == 0) ? 32'd2 : 32'd1);
            check("ct_rsp_data", 32'(rsp_data), (k % 2 == 0) ? 32'h11 : 32'h22);
            cyc(); #1;
        end

        // Back-to-back spacing with req0 alone
        req1_valid = 1'b0;
        rsp1_ready = 1'b0;
        a0 = apply_cnt;
        repeat (22) cyc();
        #1;
        check("sp_count", 32'(apply_cnt - a0), 32'd5);
        check("sp_gap", 32'(apply_gap), 32'd5);
        req0_valid = 1'b0;
        repeat (8) cyc();
        #1;
        check("sp_idle", 32'(busy), 32'd0);
        rsp0_ready = 1'b0;

        // Error path: push 0, push 8, divide, then push 3
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        #1;
        run0(8'h00, 3'd0, d, e, er);
        check("er_p0", 32'({d, e, er}), 32'h000);
        run0(8'h08, 3'd0, d, e, er);
        check("er_p8", 32'({d, e, er}), 32'h020);
        run0(8'h00, 3'd4, d, e, er);
        check("er_div_err", 32'(er), 32'd1);
`ifdef CALC_SEQ_AUTOCLR_EN
        check("er_clr_pulse", 32'({m_clr, busy}), 32'd3);
        cyc(); #1;
        check("er_clr_done", 32'({m_clr, busy}), 32'd0);
        run0(8'h03, 3'd0, d, e, er);
        check("er_after_clr", 32'({d, e, er}), 32'h00C);
`else
        check("er_idle", 32'(busy), 32'd0);
        run0(8'h03, 3'd0, d, e, er);
        check("er_sticky", 32'({d, e, er}), 32'h021);
`endif

        check("never_both_rsp", 32'(both_rsp), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "watchdog");
    end

endmodule
